// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: one outstanding imem request, FIFO_DEPTH-entry instruction queue, redirect with flush.
// Optional build macro IF_PREFETCH_PERF_EN adds perf_fetch_cnt / perf_flush_cnt counters.
module if_prefetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [XLEN-1:0]               imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [31:0]                   imem_rsp_data,
    input  logic                          imem_rsp_err,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [31:0]                   instr_data,
    output logic [XLEN-1:0]               instr_pc,
    output logic                          instr_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0]                   perf_fetch_cnt,
    output logic [31:0]                   perf_flush_cnt
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD, S_HALT} state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     data;
        logic            err;
    } entry_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    entry_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            req_fire, push, pop;

    // Gated by rst so no request is visible while reset is held.
    assign imem_req_valid = rst && (state_q == S_REQ) && (count_q < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push        = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    assign instr_data = mem_q[rd_ptr_q].data;
    assign instr_pc   = mem_q[rd_ptr_q].pc;
    assign instr_err  = mem_q[rd_ptr_q].err;
    assign fifo_count = count_q;

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            unique case (state_q)
                S_REQ:             state_d = req_fire ? S_DISCARD : S_REQ;
                S_WAIT, S_DISCARD: state_d = imem_rsp_valid ? S_REQ : S_DISCARD;
                S_HALT:            state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d    = S_WAIT;
                        fetch_pc_d = fetch_pc_q + XLEN'(4);
                    end
                end
                S_WAIT:    if (imem_rsp_valid) state_d = imem_rsp_err ? S_HALT : S_REQ;
                S_DISCARD: if (imem_rsp_valid) state_d = S_REQ;
                S_HALT:    state_d = S_HALT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            // NOTE: queue storage is reset because the head entry drives instr_* directly and must read 0 out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    // fetch_pc_q already points past the word this response belongs to.
                    mem_q[wr_ptr_q] <= '{pc: fetch_pc_q - XLEN'(4), data: imem_rsp_data, err: imem_rsp_err};
                    wr_ptr_q        <= wr_ptr_q + PW'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
                if (push && !pop)      count_q <= count_q + CW'(1);
                else if (pop && !push) count_q <= count_q - CW'(1);
            end
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (push)           perf_fetch_q <= perf_fetch_q + 32'd1;
            if (redirect_valid) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    // Default build carries no performance counters.
`endif

endmodule
